// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse playback sequencer.
package morse_pkg;

    // Playback phases of the sequencer.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MARK     = 3'd1,
        S_SYM_GAP  = 3'd2,
        S_LET_GAP  = 3'd3,
        S_WORD_GAP = 3'd4
    } state_t;

    // Durations in Morse time units.
    localparam logic [2:0] DOT_UNITS      = 3'd1;
    localparam logic [2:0] DASH_UNITS     = 3'd3;
    localparam logic [2:0] SYM_GAP_UNITS  = 3'd1;
    localparam logic [2:0] LET_GAP_UNITS  = 3'd3;
    localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

    // Longest letter the table can describe.
    localparam logic [2:0] MAX_SYMS = 3'd5;

    // One letter-table entry: symbol count and symbols, LSB first, 1 = dash.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] bits;
    } letter_t;

    // Lengths 6 and 7 cannot be represented by five symbol bits; play them as 5.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > MAX_SYMS) ? MAX_SYMS : len;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler producing one unit_tick every UNIT_CYCLES clocks, restartable.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic unit_tick
);

    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(UNIT_CYCLES - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // The tick comes straight from the count so a state change that it
    // triggers can clear the count in the same cycle without a loop.
    assign unit_tick = (cnt_q == LAST);

    // Next count: clear on request (state entry) or at the end of a unit.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || unit_tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/morse_player.sv
// Autonomous Morse sequencer: plays a word from a small letter table on the
// LED with standard Morse timing and loops with a word gap until stopped.
module morse_player
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12500000,
    parameter int MAX_LETTERS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_we,
    input  logic [$clog2(MAX_LETTERS)-1:0] cfg_idx,
    input  logic [2:0]                     cfg_len,
    input  logic [4:0]                     cfg_bits,
    input  logic [$clog2(MAX_LETTERS):0]   word_len,
    input  logic                           start,
    input  logic                           stop,
    output logic                           morse_led,
    output logic                           busy,
    output logic [$clog2(MAX_LETTERS)-1:0] letter_idx
);

    localparam int IDX_W = $clog2(MAX_LETTERS);
    localparam int SW    = IDX_W + 1;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } hit_t;

    // Lowest non-empty entry in [from, wlen); empty letters are skipped for free.
    function automatic hit_t find_first(input logic [MAX_LETTERS-1:0] mask,
                                        input logic [SW-1:0]          from,
                                        input logic [SW-1:0]          wlen);
        hit_t h;
        h.found = 1'b0;
        h.idx   = '0;
        for (int j = MAX_LETTERS - 1; j >= 0; j--) begin
            if (mask[j] && (SW'(j) >= from) && (SW'(j) < wlen)) begin
                h.found = 1'b1;
                h.idx   = IDX_W'(j);
            end
        end
        return h;
    endfunction

    letter_t                table_q [MAX_LETTERS];
    logic [MAX_LETTERS-1:0] nz_mask;

    state_t           state_q, state_d;
    logic [2:0]       unit_q, unit_d;
    logic [2:0]       sym_idx_q, sym_idx_d;
    logic [2:0]       cur_len_q, cur_len_d;
    logic [4:0]       cur_bits_q, cur_bits_d;
    logic [IDX_W-1:0] letter_idx_q, letter_idx_d;
    logic [SW-1:0]    wlen_q, wlen_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;

    logic             unit_tick;
    logic             timer_clr;
    logic             fetch;
    logic [IDX_W-1:0] fetch_idx;
    logic [2:0]       last_unit;
    logic             done;
    hit_t             hit_next;
    hit_t             hit_wrap;
    hit_t             hit_start;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (timer_clr),
        .unit_tick(unit_tick)
    );

    // Letter table: written by firmware, read only when a letter is fetched,
    // so a same-cycle write and fetch of one entry returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LETTERS; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we) begin
            table_q[cfg_idx] <= {cfg_len, cfg_bits};
        end
    end

    for (genvar gi = 0; gi < MAX_LETTERS; gi++) begin : g_nz
        assign nz_mask[gi] = (table_q[gi].len != 3'd0);
    end

    assign hit_next  = find_first(nz_mask, SW'(letter_idx_q) + SW'(1), wlen_q);
    assign hit_wrap  = find_first(nz_mask, '0, wlen_q);
    assign hit_start = find_first(nz_mask, '0, word_len);

    // Last unit index of the current state (duration minus one).
    always_comb begin
        last_unit = 3'd0;
        case (state_q)
            S_MARK:     last_unit = (cur_bits_q[sym_idx_q] ? DASH_UNITS : DOT_UNITS) - 3'd1;
            S_SYM_GAP:  last_unit = SYM_GAP_UNITS - 3'd1;
            S_LET_GAP:  last_unit = LET_GAP_UNITS - 3'd1;
            S_WORD_GAP: last_unit = WORD_GAP_UNITS - 3'd1;
            default:    last_unit = 3'd0;
        endcase
    end

    assign done = unit_tick && (unit_q == last_unit);

    // Next-state, letter fetch and output decode.
    always_comb begin
        state_d      = state_q;
        unit_d       = unit_tick ? unit_q + 3'd1 : unit_q;
        sym_idx_d    = sym_idx_q;
        cur_len_d    = cur_len_q;
        cur_bits_d   = cur_bits_q;
        letter_idx_d = letter_idx_q;
        wlen_d       = wlen_q;
        fetch        = 1'b0;
        fetch_idx    = '0;
        timer_clr    = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
        end else if (start && hit_start.found) begin
            fetch     = 1'b1;
            fetch_idx = hit_start.idx;
            wlen_d    = word_len;
        end else begin
            case (state_q)
                S_MARK: begin
                    if (done) begin
                        if ((sym_idx_q + 3'd1) < cur_len_q) begin
                            state_d   = S_SYM_GAP;
                            sym_idx_d = sym_idx_q + 3'd1;
                        end else if (hit_next.found) begin
                            state_d = S_LET_GAP;
                        end else begin
                            state_d = S_WORD_GAP;
                        end
                    end
                end
                S_SYM_GAP: begin
                    if (done) begin
                        state_d = S_MARK;
                    end
                end
                S_LET_GAP: begin
                    // Re-search here: the table may have been edited during the gap.
                    if (done) begin
                        if (hit_next.found) begin
                            fetch     = 1'b1;
                            fetch_idx = hit_next.idx;
                        end else if (hit_wrap.found) begin
                            fetch     = 1'b1;
                            fetch_idx = hit_wrap.idx;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_WORD_GAP: begin
                    if (done) begin
                        if (hit_wrap.found) begin
                            fetch     = 1'b1;
                            fetch_idx = hit_wrap.idx;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (fetch) begin
            state_d      = S_MARK;
            letter_idx_d = fetch_idx;
            cur_len_d    = clamp_len(table_q[fetch_idx].len);
            cur_bits_d   = table_q[fetch_idx].bits;
            sym_idx_d    = 3'd0;
        end

        // Every state entry (including a restarted MARK) begins a whole unit.
        if (fetch || (state_d != state_q) || (state_q == S_IDLE)) begin
            timer_clr = 1'b1;
            unit_d    = 3'd0;
        end

        led_d  = (state_d == S_MARK);
        busy_d = (state_d != S_IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            unit_q       <= 3'd0;
            sym_idx_q    <= 3'd0;
            cur_len_q    <= 3'd0;
            cur_bits_q   <= 5'd0;
            letter_idx_q <= '0;
            wlen_q       <= '0;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_q       <= unit_d;
            sym_idx_q    <= sym_idx_d;
            cur_len_q    <= cur_len_d;
            cur_bits_q   <= cur_bits_d;
            letter_idx_q <= letter_idx_d;
            wlen_q       <= wlen_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
        end
    end

    assign morse_led  = led_q;
    assign busy       = busy_q;
    assign letter_idx = letter_idx_q;

endmodule

// File: tb/tb_morse_player.sv
// Directed bench for morse_player with UNIT_CYCLES=4 (dot 4, dash 12, gaps 4/12/28).
module tb_morse_player;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [2:0] cfg_len;
    logic [4:0] cfg_bits;
    logic [3:0] word_len;
    logic       start;
    logic       stop;
    logic       morse_led;
    logic       busy;
    logic [2:0] letter_idx;

    int n_checks = 0;
    int n_pass   = 0;

    morse_player #(
        .UNIT_CYCLES(4),
        .MAX_LETTERS(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_len   (cfg_len),
        .cfg_bits  (cfg_bits),
        .word_len  (word_len),
        .start     (start),
        .stop      (stop),
        .morse_led (morse_led),
        .busy      (busy),
        .letter_idx(letter_idx)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Samples the LED on n consecutive negedges and requires all at 'level'.
    task automatic expect_run(input string tag, input int level, input int n);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (int'(morse_led) == level) cnt++;
            @(negedge clk);
        end
        check_val(tag, cnt, n);
        $display("run %s level=%0d cycles=%0d matched=%0d", tag, level, n, cnt);
    endtask

    // pat uses '.' and '-'; gap_units is the off-time after the letter (0 = none).
    task automatic check_letter(input string tag, input int idx, input string pat,
                                input int gap_units);
        check_val({tag, "_idx"}, int'(letter_idx), idx);
        for (int i = 0; i < pat.len(); i++) begin
            expect_run({tag, "_on"}, 1, (pat[i] == "-") ? 12 : 4);
            if (i < pat.len() - 1) expect_run({tag, "_sg"}, 0, 4);
        end
        if (gap_units > 0) expect_run({tag, "_gap"}, 0, gap_units * 4);
    endtask

    task automatic write_entry(input int idx, input int len, input int bits);
        cfg_we   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_len  = 3'(len);
        cfg_bits = 5'(bits);
        @(negedge clk);
        cfg_we   = 1'b0;
        $display("write entry %0d len=%0d bits=%05b", idx, len, bits);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic load_sos();
        write_entry(0, 3, 5'b00000);
        write_entry(1, 3, 5'b00111);
        write_entry(2, 3, 5'b00000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_idx  = '0;
        cfg_len  = '0;
        cfg_bits = '0;
        word_len = '0;
        start    = 1'b0;
        stop     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_led", int'(morse_led), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_idx", int'(letter_idx), 0);

        // 1: SOS looping, two full 136-cycle periods.
        load_sos();
        word_len = 4'd3;
        pulse_start();
        check_val("sos_busy", int'(busy), 1);
        for (int p = 0; p < 2; p++) begin
            check_letter("sos_s0", 0, "...", 3);
            check_letter("sos_o1", 1, "---", 3);
            check_letter("sos_s2", 2, "...", 7);
        end

        // 2: asynchronous reset mid-MARK, then start on an empty table.
        check_val("wrap_idx", int'(letter_idx), 0);
        expect_run("pre_rst", 1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_led", int'(morse_led), 0);
        check_val("arst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        word_len = 4'd3;
        pulse_start();
        check_val("empty_busy", int'(busy), 0);
        check_val("empty_led", int'(morse_led), 0);

        // 3: stop in LET_GAP, start+stop together, start with word_len 0.
        load_sos();
        pulse_start();
        check_letter("st_s0", 0, "...", 0);
        expect_run("st_lg", 0, 2);
        check_val("st_busy_pre", int'(busy), 1);
        pulse_stop();
        check_val("stop_led", int'(morse_led), 0);
        check_val("stop_busy", int'(busy), 0);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check_val("ss_busy", int'(busy), 0);
        word_len = 4'd0;
        pulse_start();
        check_val("wl0_busy", int'(busy), 0);
        word_len = 4'd3;

        // 4: edit entries 2 (S->T) and 0 (S->"--") during letter 0.
        pulse_start();
        check_val("ed_idx0", int'(letter_idx), 0);
        expect_run("ed_on0a", 1, 1);
        write_entry(2, 1, 5'b00001);
        write_entry(0, 2, 5'b00011);
        expect_run("ed_on0b", 1, 1);
        expect_run("ed_sg0", 0, 4);
        expect_run("ed_on1", 1, 4);
        expect_run("ed_sg1", 0, 4);
        expect_run("ed_on2", 1, 4);
        expect_run("ed_lg", 0, 12);
        check_letter("ed_o1", 1, "---", 3);
        check_letter("ed_t2", 2, "-", 7);
        check_letter("ed_w0", 0, "--", 3);

        // 6: start while mid-dash of letter 1 restarts letter 0 immediately.
        check_val("rs_idx1", int'(letter_idx), 1);
        expect_run("rs_dash", 1, 6);
        start = 1'b1;
        check_val("rs_led", int'(morse_led), 1);
        @(negedge clk);
        start = 1'b0;
        check_letter("rs_l0", 0, "--", 3);
        check_val("rs_idx_next", int'(letter_idx), 1);

        // 5: full-depth word with an empty entry and an over-long entry.
        pulse_stop();
        write_entry(0, 1, 5'b00000);
        write_entry(1, 1, 5'b00001);
        write_entry(2, 2, 5'b00010);
        write_entry(3, 0, 5'b00000);
        write_entry(4, 2, 5'b00001);
        write_entry(5, 7, 5'b11111);
        write_entry(6, 1, 5'b00000);
        write_entry(7, 1, 5'b00001);
        word_len = 4'd8;
        pulse_start();
        check_letter("bw_0", 0, ".", 3);
        check_letter("bw_1", 1, "-", 3);
        check_letter("bw_2", 2, ".-", 3);
        check_letter("bw_4", 4, "-.", 3);
        check_letter("bw_5", 5, "-----", 3);
        check_letter("bw_6", 6, ".", 3);
        check_letter("bw_7", 7, "-", 7);
        check_letter("bw_w0", 0, ".", 3);
        check_val("bw_busy", int'(busy), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
